// File: rtl/ifu_pc_gen_pkg.sv
// Shared constants, RAS operation encoding and immediate decoders for the
// fetch-stage PC generator.
package ifu_pc_gen_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic        STOP       = 1'b1;
    localparam logic        NOSTOP     = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RAS_NOP,
        RAS_PUSH,
        RAS_POP
    } ras_op_e;

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // x1 and x5 are the link registers used by call/return conventions.
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ifu_pc_gen_ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten
// when full; the count saturates at DEPTH.
module ifu_ras
    import ifu_pc_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;

    assign top_o   = mem_q[ptr_q - PW'(1)];
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ZERO_WORD;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
            ptr_q        <= ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator with static prediction: backward branches and JAL taken,
// returns predicted from the RAS; flush and exu redirects override everything.
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        branch_redirect_i,
    input  logic [31:0] branch_redirect_addr_i,
    input  logic [31:0] inst_i,
    output logic        ce_o,
    output logic [31:0] pc_o,
    output logic [31:0] next_pc_o,
    output logic        next_taken_o
);

    logic        ce_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    ras_op_e     ras_op;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        advance;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        unused_stall;

    assign unused_stall = ^stall_i[5:1];

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        opcode     = inst_i[6:0];
        rd         = inst_i[11:7];
        rs1        = inst_i[19:15];
        pred_taken = 1'b0;
        pred_pc    = pc_plus4;
        ras_op     = RAS_NOP;
        if (ce_q) begin
            case (opcode)
                OPC_JAL: begin
                    pred_taken = 1'b1;
                    pred_pc    = pc_q + imm_j(inst_i);
                    if (is_link(rd)) ras_op = RAS_PUSH;
                end
                OPC_BRANCH: begin
                    if (inst_i[31]) begin
                        pred_taken = 1'b1;
                        pred_pc    = pc_q + imm_b(inst_i);
                    end
                end
                OPC_JALR: begin
                    if (rd == 5'd0 && is_link(rs1) && !ras_empty) begin
                        pred_taken = 1'b1;
                        pred_pc    = ras_top;
                        ras_op     = RAS_POP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only an edge that follows the prediction may commit RAS push/pop.
    assign advance = ce_q && !flush_i && !branch_redirect_i && (stall_i[0] != STOP);

    always_comb begin
        pc_d = pc_q;
        if (flush_i)                pc_d = flush_addr_i;
        else if (branch_redirect_i) pc_d = branch_redirect_addr_i;
        else if (advance)           pc_d = pred_pc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_q <= 1'b0;
            pc_q <= RESET_VEC;
        end else begin
            ce_q <= 1'b1;
            pc_q <= pc_d;
        end
    end

    ifu_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (advance && (ras_op == RAS_PUSH)),
        .pop_i       (advance && (ras_op == RAS_POP)),
        .clear_i     (flush_i),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    assign ce_o         = ce_q;
    assign pc_o         = pc_q;
    assign next_pc_o    = pred_pc;
    assign next_taken_o = pred_taken;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Self-checking bench for ifu_pc_gen: prediction table, directed RAS/stall/
// flush/reset sequences and randomized traffic against a queue-based model.
module tb_ifu_pc_gen;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        rst_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        branch_redirect_i;
    logic [31:0] branch_redirect_addr_i;
    logic [31:0] inst_i;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] next_pc_o;
    logic        next_taken_o;

    ifu_pc_gen #(
        .RESET_VEC (RESET_VEC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .stall_i                (stall_i),
        .flush_i                (flush_i),
        .flush_addr_i           (flush_addr_i),
        .branch_redirect_i      (branch_redirect_i),
        .branch_redirect_addr_i (branch_redirect_addr_i),
        .inst_i                 (inst_i),
        .ce_o                   (ce_o),
        .pc_o                   (pc_o),
        .next_pc_o              (next_pc_o),
        .next_taken_o           (next_taken_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    // ---------------- reference model ----------------
    bit          mdl_ce;
    logic [31:0] mdl_pc;
    logic [31:0] ras[$];

    function automatic void mdl_reset();
        mdl_ce = 1'b0;
        mdl_pc = RESET_VEC;
        ras.delete();
    endfunction

    function automatic void predict(input logic [31:0] pc, input logic [31:0] ins, input bit ce,
                                    output bit tk, output logic [31:0] np,
                                    output bit pu, output bit po);
        logic [31:0] opc, rd, rs1, off;
        opc = ins & 32'h7F;
        rd  = (ins >> 7) & 32'h1F;
        rs1 = (ins >> 15) & 32'h1F;
        tk = 0; pu = 0; po = 0;
        np = pc + 32'd4;
        if (!ce) return;
        if (opc == 32'h6F) begin
            off = (((ins >> 21) & 32'h3FF) << 1) | (((ins >> 20) & 32'h1) << 11)
                | (((ins >> 12) & 32'hFF) << 12);
            if (ins[31]) off = off - 32'h0010_0000;
            tk = 1; np = pc + off;
            pu = (rd == 1 || rd == 5);
        end else if (opc == 32'h63) begin
            if (ins[31]) begin
                off = (((ins >> 8) & 32'hF) << 1) | (((ins >> 25) & 32'h3F) << 5)
                    | (((ins >> 7) & 32'h1) << 11);
                off = off - 32'h0000_1000;
                tk = 1; np = pc + off;
            end
        end else if (opc == 32'h67) begin
            if (rd == 0 && (rs1 == 1 || rs1 == 5) && ras.size() > 0) begin
                tk = 1; np = ras[$]; po = 1;
            end
        end
    endfunction

    task automatic cycle(input logic [5:0] st, input logic fl, input logic [31:0] fa,
                         input logic rdr, input logic [31:0] ra, input logic [31:0] ins);
        bit          tk, pu, po;
        logic [31:0] np;
        stall_i = st; flush_i = fl; flush_addr_i = fa;
        branch_redirect_i = rdr; branch_redirect_addr_i = ra; inst_i = ins;
        #1;
        predict(mdl_pc, ins, mdl_ce, tk, np, pu, po);
        chk("ce_o", {31'b0, ce_o}, {31'b0, mdl_ce});
        chk("pc_o", pc_o, mdl_pc);
        chk("next_pc_o", next_pc_o, np);
        chk("next_taken_o", {31'b0, next_taken_o}, {31'b0, tk});
        @(posedge clk);
        if (fl) begin
            mdl_pc = fa;
            ras.delete();
        end else if (rdr) begin
            mdl_pc = ra;
        end else if (mdl_ce && !st[0]) begin
            if (pu) begin
                ras.push_back(mdl_pc + 32'd4);
                if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
            end
            if (po) void'(ras.pop_back());
            mdl_pc = np;
        end
        mdl_ce = 1'b1;
        #1;
    endtask

    // ---------------- directed program memory ----------------
    logic [31:0] rom [logic [31:0]];

    function automatic logic [31:0] rom_get(input logic [31:0] a);
        return rom.exists(a) ? rom[a] : NOP;
    endfunction

    task automatic cyc_rom(input logic [5:0] st, input logic fl, input logic [31:0] fa,
                           input logic rdr, input logic [31:0] ra);
        cycle(st, fl, fa, rdr, ra, rom_get(mdl_pc));
    endtask

    task automatic step();
        cyc_rom(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic peek(input string nm, input logic [31:0] exp_np, input logic exp_tk);
        stall_i = 6'h00; flush_i = 1'b0; branch_redirect_i = 1'b0;
        inst_i = rom_get(mdl_pc);
        #1;
        chk({nm, "_next"}, next_pc_o, exp_np);
        chk({nm, "_taken"}, {31'b0, next_taken_o}, {31'b0, exp_tk});
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] next;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] ret_x1;

    initial begin
        ret_x1 = enc_jalr(5'd0, 5'd1, 12'h000);
        vecs[0] = '{32'h0000_0100, enc_beq(-32'sd8),             1'b1, 32'h0000_00F8};
        vecs[1] = '{32'h0000_0100, enc_beq(32'd8),               1'b0, 32'h0000_0104};
        vecs[2] = '{32'h0000_0200, enc_jal(5'd1, 32'h40),        1'b1, 32'h0000_0240};
        vecs[3] = '{32'h0000_0240, ret_x1,                       1'b0, 32'h0000_0244};
        vecs[4] = '{32'hFFFF_FFFC, enc_jal(5'd0, 32'd8),         1'b1, 32'h0000_0004};
        vecs[5] = '{32'h0000_0300, NOP,                          1'b0, 32'h0000_0304};
        vecs[6] = '{32'h0000_0300, enc_jalr(5'd1, 5'd1, 12'h0),  1'b0, 32'h0000_0304};
        vecs[7] = '{32'h0000_0000, enc_beq(-32'sd4),             1'b1, 32'hFFFF_FFFC};
        vecs[8] = '{32'h0000_0400, enc_jal(5'd0, -32'sd1024),    1'b1, 32'h0000_0000};

        rst_i = 1'b1; stall_i = '0; flush_i = 1'b0; flush_addr_i = '0;
        branch_redirect_i = 1'b0; branch_redirect_addr_i = '0; inst_i = NOP;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce", {31'b0, ce_o}, 32'h0);
        chk("rst_pc", pc_o, RESET_VEC);
        rst_i = 1'b0;

        // Reset release with NOP stream: first fetch is RESET_VEC twice.
        step();
        chk("ce_rise", {31'b0, ce_o}, 32'h1);
        chk("pc_first", pc_o, 32'h0);
        step();
        chk("pc_seq4", pc_o, 32'h4);
        step();
        chk("pc_seq8", pc_o, 32'h8);

        // Prediction table, evaluated while stalled so the RAS stays untouched.
        cyc_rom(6'h00, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        foreach (vecs[i]) begin
            cycle(6'h00, 1'b0, 32'h0, 1'b1, vecs[i].pc, NOP);
            stall_i = 6'h01; inst_i = vecs[i].inst;
            #1;
            chk($sformatf("vec%0d_next", i), next_pc_o, vecs[i].next);
            chk($sformatf("vec%0d_taken", i), {31'b0, next_taken_o}, {31'b0, vecs[i].taken});
            cycle(6'h01, 1'b0, 32'h0, 1'b0, 32'h0, vecs[i].inst);
        end

        // JAL then return, then a return with an empty RAS.
        rom[32'h200] = enc_jal(5'd1, 32'h40);
        rom[32'h240] = ret_x1;
        cyc_rom(6'h00, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("jal_pc", pc_o, 32'h200);
        step();
        chk("jal_tgt", pc_o, 32'h240);
        peek("ret", 32'h204, 1'b1);
        step();
        chk("ret_pc", pc_o, 32'h204);
        cyc_rom(6'h00, 1'b0, 32'h0, 1'b1, 32'h240);
        peek("ret_empty", 32'h244, 1'b0);
        step();
        chk("ret_empty_pc", pc_o, 32'h244);

        // Six nested calls, RAS depth 4: four LIFO returns then a miss.
        for (int k = 0; k < 6; k++) rom[32'h500 + 32'(k * 16)] = enc_jal(5'd1, 32'h10);
        rom[32'h560] = ret_x1;
        for (int k = 2; k < 6; k++) rom[32'h504 + 32'(k * 16)] = ret_x1;
        cyc_rom(6'h00, 1'b1, 32'h500, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) step();
        chk("nest_pc", pc_o, 32'h560);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("nest_pop%0d", k), pc_o, 32'h554 - 32'(k * 16));
        end
        peek("nest_pop5", 32'h528, 1'b0);

        // Stall across a JAL: exactly one push.
        rom[32'h600] = enc_jal(5'd1, 32'h20);
        rom[32'h620] = ret_x1;
        rom[32'h604] = ret_x1;
        cyc_rom(6'h00, 1'b1, 32'h600, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc_rom(6'h01, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("stall_hold", pc_o, 32'h600);
        end
        step();
        chk("stall_jal_tgt", pc_o, 32'h620);
        step();
        chk("stall_ret", pc_o, 32'h604);
        peek("stall_one_push", 32'h608, 1'b0);
        cyc_rom(6'h01, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("redir_stalled", pc_o, 32'h80);

        // Flush and redirect together: flush wins and clears the RAS.
        rom[32'h700]  = enc_jal(5'd1, 32'h8);
        rom[32'h708]  = ret_x1;
        rom[32'h1000] = ret_x1;
        cyc_rom(6'h00, 1'b1, 32'h700, 1'b0, 32'h0);
        step();
        peek("pre_flush_ret", 32'h704, 1'b1);
        cyc_rom(6'h00, 1'b1, 32'h1000, 1'b1, 32'h80);
        chk("flush_wins", pc_o, 32'h1000);
        peek("flush_clr", 32'h1004, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        step();
        step();
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_ce", {31'b0, ce_o}, 32'h0);
        chk("async_pc", pc_o, RESET_VEC);
        mdl_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        step();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            logic [4:0]  r;
            logic [5:0]  st;
            logic        fl, rdr;
            case ($urandom_range(0, 3))
                0:       r = 5'd0;
                1:       r = 5'd1;
                2:       r = 5'd5;
                default: r = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 5))
                0:       ins = enc_jal(r, $urandom & 32'h001F_FFFE);
                1:       ins = enc_beq($urandom & 32'h0000_1FFE);
                2:       ins = enc_jalr(5'd0, ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5,
                                        12'($urandom));
                3:       ins = enc_jalr(r, 5'($urandom), 12'($urandom));
                4:       ins = $urandom;
                default: ins = NOP;
            endcase
            st  = 6'($urandom);
            st[0] = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 29) == 0);
            rdr = ($urandom_range(0, 19) == 0);
            cycle(st, fl, $urandom & 32'hFFFF_FFFC, rdr, $urandom & 32'hFFFF_FFFC, ins);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
